// File: rtl/iter_div_if.sv
// Request/response bundle for the iterative divider.
// The master issues operands and consumes results; the slave is the divider.
interface iter_div_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;

  modport master (
    output in_valid, in_signed, dividend, divisor, cancel, out_ready,
    input  in_ready, out_valid, quotient, remainder, busy
  );

  modport slave (
    input  in_valid, in_signed, dividend, divisor, cancel, out_ready,
    output in_ready, out_valid, quotient, remainder, busy
  );
endinterface

// File: rtl/iter_div.sv
// Iterative radix-2 restoring divider, signed or unsigned per request.
// Works on operand magnitudes and fixes the signs on the final step.
module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  iter_div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic             qNeg_q, qNeg_d;
  logic             rNeg_q, rNeg_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remOut_q, remOut_d;

  logic             dvdNeg, dvsNeg;
  logic [WIDTH-1:0] dvdMag, dvsMag;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] stepRem, stepQuot;

  assign dvdNeg = bus.in_signed & bus.dividend[WIDTH-1];
  assign dvsNeg = bus.in_signed & bus.divisor[WIDTH-1];
  assign dvdMag = dvdNeg ? (~bus.dividend + 1'b1) : bus.dividend;
  assign dvsMag = dvsNeg ? (~bus.divisor + 1'b1) : bus.divisor;

  // The dividend register doubles as the quotient: MSBs shift out, quotient bits shift in.
  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign stepRem  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign stepQuot = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      raw_q     <= '0;
      qNeg_q    <= 1'b0;
      rNeg_q    <= 1'b0;
      divZero_q <= 1'b0;
      quot_q    <= '0;
      remOut_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      raw_q     <= raw_d;
      qNeg_q    <= qNeg_d;
      rNeg_q    <= rNeg_d;
      divZero_q <= divZero_d;
      quot_q    <= quot_d;
      remOut_q  <= remOut_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    raw_d     = raw_q;
    qNeg_d    = qNeg_q;
    rNeg_d    = rNeg_q;
    divZero_d = divZero_q;
    quot_d    = quot_q;
    remOut_d  = remOut_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && !bus.cancel) begin
          dvd_d     = dvdMag;
          dvs_d     = dvsMag;
          rem_d     = '0;
          raw_d     = bus.dividend;
          qNeg_d    = dvdNeg ^ dvsNeg;
          rNeg_d    = dvdNeg;
          divZero_d = (bus.divisor == '0);
          cnt_d     = CW'(WIDTH);
          state_d   = CALC;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = stepRem;
          dvd_d = stepQuot;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // Divide-by-zero overrides whatever the magnitude path produced.
            quot_d   = divZero_q ? '1 : (qNeg_q ? (~stepQuot + 1'b1) : stepQuot);
            remOut_d = divZero_q ? raw_q : (rNeg_q ? (~stepRem + 1'b1) : stepRem);
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (bus.cancel || bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = remOut_q;
endmodule
